// File: rtl/mult_axi_pkg.sv
// Shared definitions for the multiplier register map and the AXI4-Lite
// master sequencer that drives it.
package mult_axi_pkg;

  // Register offsets inside the multiplier slave
  localparam int OFFS_OPA = 'h10;
  localparam int OFFS_OPB = 'h14;
  localparam int OFFS_RES = 'h18;
  localparam int OFFS_OVF = 'h1C;

  // Single-bit response encoding used on bresp/rresp
  localparam logic RESP_OK = 1'b1;

  // Sequencer states, in the order a clean transaction walks them
  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_WR_A        = 4'd1,
    S_WR_A_RESP   = 4'd2,
    S_WR_B        = 4'd3,
    S_WR_B_RESP   = 4'd4,
    S_RD_RES      = 4'd5,
    S_RD_RES_DATA = 4'd6,
    S_RD_OVF      = 4'd7,
    S_RD_OVF_DATA = 4'd8,
    S_DONE        = 4'd9
  } state_e;

  // Status codes returned alongside the result
  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_RESP    = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_e;

  // True for states that wait on a slave handshake and are watchdog guarded
  function automatic logic isWaitState(state_e s);
    logic waitState;
    waitState = 1'b0;
    case (s)
      S_WR_A, S_WR_A_RESP, S_WR_B, S_WR_B_RESP,
      S_RD_RES, S_RD_RES_DATA, S_RD_OVF, S_RD_OVF_DATA: waitState = 1'b1;
      default: waitState = 1'b0;
    endcase
    return waitState;
  endfunction

endpackage

// File: rtl/mult_axi_master_if.sv
// AXI4-Lite bus between the sequencer (master) and the multiplier (slave).
interface mult_axi_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic                    bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/mult_axi_watchdog.sv
// Per-state watchdog: cleared on the first cycle of every state, counts the
// cycles spent waiting, and flags expiry so the sequencer can abort.
module mult_axi_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Expiry is raised one cycle before the count reaches the limit, so that
  // together with the DONE cycle the done pulse lands TIMEOUT_CYCLES cycles
  // after the waiting state was entered.
  localparam logic [CW-1:0] EXPIRE_AT = CW'(TIMEOUT_CYCLES - 2);
  localparam logic [CW-1:0] SATURATE  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_elapsed;

  // Elapsed-cycle counter; the first cycle of a state counts as cycle zero
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= CW'(1);
    end else if (i_enable && (r_count != SATURATE)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign w_elapsed = i_clear ? '0 : r_count;
  assign o_expired = i_enable && (w_elapsed == EXPIRE_AT);

endmodule

// File: rtl/mult_axi_master.sv
// AXI4-Lite master that runs one multiply transaction on the multiplier
// slave: write A, write B, read result, read overflow flag, then report.
module mult_axi_master
  import mult_axi_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  m1_axi_aclk,
  input  logic                  m1_axi_aresetn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic [1:0]            err,
  mult_axi_master_if.master     m1_axi
);

  state_e                r_state;
  logic                  r_entry;
  logic [DATA_WIDTH-1:0] r_opB;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic                  r_awvalid;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_wvalid;
  logic                  r_awDone;
  logic                  r_wDone;
  logic                  r_bready;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_overflow;
  err_e                  r_err;

  logic w_awHs;
  logic w_wHs;
  logic w_awDoneNext;
  logic w_wDoneNext;
  logic w_bHs;
  logic w_arHs;
  logic w_rHs;
  logic w_waitState;
  logic w_expired;

  assign w_awHs       = r_awvalid && m1_axi.awready;
  assign w_wHs        = r_wvalid && m1_axi.wready;
  assign w_awDoneNext = r_awDone || w_awHs;
  assign w_wDoneNext  = r_wDone || w_wHs;
  assign w_bHs        = r_bready && m1_axi.bvalid;
  assign w_arHs       = r_arvalid && m1_axi.arready;
  assign w_rHs        = r_rready && m1_axi.rvalid;
  assign w_waitState  = isWaitState(r_state);

  mult_axi_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (m1_axi_aclk),
    .rstn     (m1_axi_aresetn),
    .i_clear  (r_entry),
    .i_enable (w_waitState),
    .o_expired(w_expired)
  );

  // Sequencer FSM; every bus and status output is a register set here.
  // r_entry pulses in the first cycle of each new state to restart the
  // watchdog. A completed handshake always wins over a same-cycle timeout.
  always_ff @(posedge m1_axi_aclk) begin
    if (!m1_axi_aresetn) begin
      r_state    <= S_IDLE;
      r_entry    <= 1'b0;
      r_opB      <= '0;
      r_awaddr   <= '0;
      r_awvalid  <= 1'b0;
      r_wdata    <= '0;
      r_wvalid   <= 1'b0;
      r_awDone   <= 1'b0;
      r_wDone    <= 1'b0;
      r_bready   <= 1'b0;
      r_araddr   <= '0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_err      <= ERR_OK;
    end else begin
      r_done  <= 1'b0;
      r_entry <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_opB     <= operand_b;
            r_err     <= ERR_OK;
            r_busy    <= 1'b1;
            r_awaddr  <= ADDR_WIDTH'(OFFS_OPA);
            r_wdata   <= operand_a;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_awDone  <= 1'b0;
            r_wDone   <= 1'b0;
            r_state   <= S_WR_A;
            r_entry   <= 1'b1;
          end
        end

        S_WR_A, S_WR_B: begin
          if (w_awHs) r_awvalid <= 1'b0;
          if (w_wHs)  r_wvalid  <= 1'b0;
          r_awDone <= w_awDoneNext;
          r_wDone  <= w_wDoneNext;
          if (w_awDoneNext && w_wDoneNext) begin
            r_bready <= 1'b1;
            r_state  <= (r_state == S_WR_A) ? S_WR_A_RESP : S_WR_B_RESP;
            r_entry  <= 1'b1;
          end else if (w_expired) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_err     <= ERR_TIMEOUT;
            r_state   <= S_DONE;
            r_entry   <= 1'b1;
          end
        end

        S_WR_A_RESP: begin
          if (w_bHs) begin
            r_bready <= 1'b0;
            r_entry  <= 1'b1;
            if (m1_axi.bresp == RESP_OK) begin
              r_awaddr  <= ADDR_WIDTH'(OFFS_OPB);
              r_wdata   <= r_opB;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_awDone  <= 1'b0;
              r_wDone   <= 1'b0;
              r_state   <= S_WR_B;
            end else begin
              r_err   <= ERR_RESP;
              r_state <= S_DONE;
            end
          end else if (w_expired) begin
            r_bready <= 1'b0;
            r_err    <= ERR_TIMEOUT;
            r_state  <= S_DONE;
            r_entry  <= 1'b1;
          end
        end

        S_WR_B_RESP: begin
          if (w_bHs) begin
            r_bready <= 1'b0;
            r_entry  <= 1'b1;
            if (m1_axi.bresp == RESP_OK) begin
              r_araddr  <= ADDR_WIDTH'(OFFS_RES);
              r_arvalid <= 1'b1;
              r_state   <= S_RD_RES;
            end else begin
              r_err   <= ERR_RESP;
              r_state <= S_DONE;
            end
          end else if (w_expired) begin
            r_bready <= 1'b0;
            r_err    <= ERR_TIMEOUT;
            r_state  <= S_DONE;
            r_entry  <= 1'b1;
          end
        end

        S_RD_RES, S_RD_OVF: begin
          if (w_arHs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= (r_state == S_RD_RES) ? S_RD_RES_DATA : S_RD_OVF_DATA;
            r_entry   <= 1'b1;
          end else if (w_expired) begin
            r_arvalid <= 1'b0;
            r_err     <= ERR_TIMEOUT;
            r_state   <= S_DONE;
            r_entry   <= 1'b1;
          end
        end

        S_RD_RES_DATA: begin
          if (w_rHs) begin
            r_rready <= 1'b0;
            r_entry  <= 1'b1;
            if (m1_axi.rresp == RESP_OK) begin
              r_result  <= m1_axi.rdata;
              r_araddr  <= ADDR_WIDTH'(OFFS_OVF);
              r_arvalid <= 1'b1;
              r_state   <= S_RD_OVF;
            end else begin
              r_err   <= ERR_RESP;
              r_state <= S_DONE;
            end
          end else if (w_expired) begin
            r_rready <= 1'b0;
            r_err    <= ERR_TIMEOUT;
            r_state  <= S_DONE;
            r_entry  <= 1'b1;
          end
        end

        S_RD_OVF_DATA: begin
          if (w_rHs) begin
            r_rready <= 1'b0;
            r_entry  <= 1'b1;
            r_state  <= S_DONE;
            if (m1_axi.rresp == RESP_OK) begin
              r_overflow <= m1_axi.rdata[0];
            end else begin
              r_err <= ERR_RESP;
            end
          end else if (w_expired) begin
            r_rready <= 1'b0;
            r_err    <= ERR_TIMEOUT;
            r_state  <= S_DONE;
            r_entry  <= 1'b1;
          end
        end

        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          r_entry <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign m1_axi.awaddr  = r_awaddr;
  assign m1_axi.awvalid = r_awvalid;
  assign m1_axi.wdata   = r_wdata;
  assign m1_axi.wstrb   = '1;
  assign m1_axi.wvalid  = r_wvalid;
  assign m1_axi.bready  = r_bready;
  assign m1_axi.araddr  = r_araddr;
  assign m1_axi.arvalid = r_arvalid;
  assign m1_axi.rready  = r_rready;

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign overflow = r_overflow;
  assign err      = r_err;

endmodule

// File: doc/mult_axi_master.md
# mult_axi_master

AXI4-Lite master sequencer sitting directly upstream of the memory-mapped multiplier slave. It takes an operand pair from a simple start/done command port and runs one complete transaction sequence on the slave: write operand A (0x10), write operand B (0x14), read result (0x18), read overflow flag (0x1C). It returns the result and overflow flag with a status code, and guards every channel wait with a watchdog.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI data width and operand/result width
- ADDR_WIDTH, 8, AXI address width
- TIMEOUT_CYCLES, 256, max cycles waited in any single handshake state before abort (≥2)

Ports:
- m1_axi_aclk  in  1  single clock; all logic on its rising edge
- m1_axi_aresetn  in  1  reset, synchronous, active-low
- start  in  1  command strobe, sampled only in IDLE
- operand_a, operand_b  in  DATA_WIDTH  operands, captured when start is accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at sequence end (success or error)
- result  out  DATA_WIDTH  word read from 0x18
- overflow  out  1  bit 0 of word read from 0x1C
- err  out  2  0 ok, 1 slave response not OK, 2 timeout
- m1_axi_awaddr out ADDR_WIDTH; m1_axi_awvalid out 1; m1_axi_awready in 1
- m1_axi_wdata out DATA_WIDTH; m1_axi_wstrb out DATA_WIDTH/8 (all ones); m1_axi_wvalid out 1; m1_axi_wready in 1
- m1_axi_bresp in 1 (1 = OK); m1_axi_bvalid in 1; m1_axi_bready out 1
- m1_axi_araddr out ADDR_WIDTH; m1_axi_arvalid out 1; m1_axi_arready in 1
- m1_axi_rdata in DATA_WIDTH; m1_axi_rresp in 1 (1 = OK); m1_axi_rvalid in 1; m1_axi_rready out 1

## Operation
- States: IDLE → WR_A → WR_A_RESP → WR_B → WR_B_RESP → RD_RES → RD_RES_DATA → RD_OVF → RD_OVF_DATA → DONE → IDLE.
- IDLE: start=1 captures operands, clears err, enters WR_A. start in any other state ignored.
- WR_x: awvalid and wvalid both raised on entry with address/data stable. Each valid drops independently in the cycle after its own valid&&ready; aw_done/w_done flags track completion; advance to WR_x_RESP when both set (same cycle allowed).
- WR_x_RESP: bready=1; on bvalid, bresp=1 → next state, bresp=0 → err=1, DONE.
- RD_x: arvalid=1 until arready; then RD_x_DATA with rready=1; on rvalid capture rdata into result (0x18) or rdata[0] into overflow (0x1C); rresp=0 → err=1, DONE.
- Watchdog: counter clears on every state entry, counts each cycle in WR/RESP/RD states; reaching TIMEOUT_CYCLES → all valids/readies low next cycle, err=2, DONE.
- On error, no further transactions issued; result/overflow keep values already captured this sequence.
- DONE: done=1 one cycle, return to IDLE. result, overflow, err hold until next accepted start.

## Timing
- Reset values: all AXI valids/readies 0, addresses/wdata 0, wstrb all ones, busy 0, done 0, result 0, overflow 0, err 0; state IDLE, counter 0.
- Reset asserted mid-sequence: next edge returns to reset values regardless of pending handshakes; no done pulse.
- Zero-wait slave (ready/valid same cycle as request): done asserted 9 cycles after start sampled.
- Valid signals never drop before their handshake except on timeout or reset; address/data stable while valid high.
- bready/rready high only in the corresponding RESP/DATA state.

## Structure
- Package mult_axi_pkg: register offsets (OPA 0x10, OPB 0x14, RES 0x18, OVF 0x1C), state enum, err codes, RESP_OK=1; shared with the multiplier slave.
- Sub-module mult_axi_watchdog: clear/enable/expired counter parameterised by TIMEOUT_CYCLES.

## Test plan
- A=3, B=5, zero-wait slave model returning 15 and 0 → writes 0x10←3, 0x14←5; result=15, overflow=0, err=0, done at cycle 9.
- A=0x00010000, B=0x00010000, slave returns 0x0 and 0x1 → result=0, overflow=1, err=0.
- awready delayed 3 cycles, wready immediate → wvalid high 1 cycle, awvalid high 4 cycles, single write per address.
- TIMEOUT_CYCLES=16, slave never asserts bvalid for operand A → err=2, done 16 cycles after WR_A_RESP entry, no B write or reads.
- bresp=0 on operand B write → err=1, no araddr issued; start during busy ignored.
- Reset dropped during RD_RES_DATA → next edge all outputs at reset values, no done; new start then completes normally.
